// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode enum, sequencer FSM state enum and default opcode count for the ALU op sequencer
package alu_pkg;
  localparam int DEF_NUM_OPS = 6;
  typedef enum logic [2:0] {OP_ADD = 3'b000, OP_SUB = 3'b001, OP_MUL = 3'b010, OP_AND = 3'b011, OP_OR = 3'b100, OP_XOR = 3'b101} opcode_t;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} seq_state_t;
endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: sweep request (start, a_in, b_in), external ALU drive (alu_a, alu_b, alu_opcode, alu_out), status (busy, done) and read port (rd_en, rd_addr, rd_data, rd_valid, rd_err); master = host/ALU side, slave = sequencer
interface alu_op_sequencer_if;
  logic start;
  logic [3:0] a_in, b_in, alu_a, alu_b;
  logic [2:0] alu_opcode, rd_addr;
  logic [7:0] alu_out, rd_data;
  logic busy, done, rd_en, rd_valid, rd_err;
  modport master (output start, a_in, b_in, alu_out, rd_en, rd_addr, input alu_a, alu_b, alu_opcode, busy, done, rd_data, rd_valid, rd_err);
  modport slave (input start, a_in, b_in, alu_out, rd_en, rd_addr, output alu_a, alu_b, alu_opcode, busy, done, rd_data, rd_valid, rd_err);
endinterface

// File: rtl/alu_result_buf.sv
// alu_result_buf: NUM_OPS x 8 result register file; ports clk, rst_n (sync clear), write port we/waddr/wdata, registered read-before-write port re/raddr -> rdata/rvalid/rerr (rerr and zero data for raddr >= NUM_OPS)
module alu_result_buf import alu_pkg::*; #(
  parameter int NUM_OPS = DEF_NUM_OPS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [2:0] waddr,
  input  logic [7:0] wdata,
  input  logic       re,
  input  logic [2:0] raddr,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       rerr
);
  logic [7:0] mem [NUM_OPS];
  logic hit;
  assign hit = {1'b0, raddr} < 4'(NUM_OPS);
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < NUM_OPS; i++) mem[i] <= '0;
      rdata <= '0;
      rvalid <= 1'b0;
      rerr <= 1'b0;
    end else begin
      if (we) mem[waddr] <= wdata;
      rvalid <= re;
      rerr <= re && !hit;
      rdata <= (re && hit) ? mem[raddr] : '0;
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: on start, latches operands and sweeps opcodes 0..NUM_OPS-1 through an external ALU, holding each SETTLE_CYC cycles then capturing alu_out into a result buffer; ports clk, rst_n (sync active-low), bus (slave modport of alu_op_sequencer_if)
module alu_op_sequencer import alu_pkg::*; #(
  parameter int NUM_OPS    = DEF_NUM_OPS,
  parameter int SETTLE_CYC = 1
) (
  input logic clk,
  input logic rst_n,
  alu_op_sequencer_if.slave bus
);
  seq_state_t state;
  logic [3:0] cnt;
  logic last;
  assign last = bus.alu_opcode == 3'(NUM_OPS - 1);
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bus.alu_a <= '0;
      bus.alu_b <= '0;
      bus.alu_opcode <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else
      case (state)
        ISSUE:
          if (cnt == 4'(SETTLE_CYC - 1)) state <= CAPTURE;
          else cnt <= cnt + 4'd1;
        CAPTURE:
          if (last) begin
            state <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            state <= ISSUE;
            cnt <= '0;
            bus.alu_opcode <= bus.alu_opcode + 3'd1;
          end
        default:
          if (bus.start) begin
            state <= ISSUE;
            cnt <= '0;
            bus.alu_a <= bus.a_in;
            bus.alu_b <= bus.b_in;
            bus.alu_opcode <= OP_ADD;
            bus.busy <= 1'b1;
            bus.done <= 1'b0;
          end
      endcase
  alu_result_buf #(.NUM_OPS(NUM_OPS)) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (state == CAPTURE),
    .waddr (bus.alu_opcode),
    .wdata (bus.alu_out),
    .re    (bus.rd_en),
    .raddr (bus.rd_addr),
    .rdata (bus.rd_data),
    .rvalid(bus.rd_valid),
    .rerr  (bus.rd_err)
  );
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and randomized sweeps checked every cycle against a timestamp-based behavioural model
module tb_alu_op_sequencer;
  import alu_pkg::*;
  localparam int N = 6, S = 1;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_op_sequencer_if bus();
  alu_op_sequencer #(.NUM_OPS(N), .SETTLE_CYC(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  function automatic logic [7:0] alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    case (op)
      3'd0: return 8'(a) + 8'(b);
      3'd1: return 8'(a) - 8'(b);
      3'd2: return 8'(a) * 8'(b);
      3'd3: return {4'h0, a & b};
      3'd4: return {4'h0, a | b};
      3'd5: return {4'h0, a ^ b};
      default: return 8'h00;
    endcase
  endfunction
  assign bus.alu_out = alu(bus.alu_a, bus.alu_b, bus.alu_opcode);
  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;
  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask
  // Model: a sweep accepted at edge s captures opcode k at edge s+(k+1)*(S+1).
  int cyc = 0, s = 0, k = 0;
  bit act = 1'b0, mdone = 1'b0, mrv = 1'b0, mre = 1'b0;
  logic [3:0] ma = '0, mb = '0;
  logic [2:0] mop = '0;
  logic [7:0] mrd = '0;
  logic [7:0] mbuf [8];
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      act = 1'b0; mdone = 1'b0; ma = '0; mb = '0; mop = '0;
      mrv = 1'b0; mre = 1'b0; mrd = '0;
      for (int i = 0; i < 8; i++) mbuf[i] = '0;
    end else begin
      mrv = bus.rd_en;
      mre = bus.rd_en && (int'(bus.rd_addr) >= N);
      mrd = (bus.rd_en && int'(bus.rd_addr) < N) ? mbuf[bus.rd_addr] : 8'h00;
      if (act) begin
        if ((cyc - s) % (S + 1) == 0) begin
          k = (cyc - s) / (S + 1) - 1;
          mbuf[k] = alu(ma, mb, 3'(k));
          if (k == N - 1) begin act = 1'b0; mdone = 1'b1; end
        end
        if (act) mop = 3'((cyc - s) / (S + 1));
      end else if (bus.start) begin
        act = 1'b1; s = cyc; ma = bus.a_in; mb = bus.b_in; mop = '0; mdone = 1'b0;
      end
    end
  end
  always @(negedge clk)
    if (chk_en) begin
      chk("busy", bus.busy, act);
      chk("done", bus.done, mdone);
      chk("alu_a", bus.alu_a, ma);
      chk("alu_b", bus.alu_b, mb);
      chk("alu_opcode", bus.alu_opcode, mop);
      chk("rd_valid", bus.rd_valid, mrv);
      chk("rd_err", bus.rd_err, mre);
      chk("rd_data", bus.rd_data, mrd);
    end
  task automatic sweep(input logic [3:0] a, input logic [3:0] b, input int rs_m, input int rd_m,
                       output int m, output logic [7:0] r0, output logic [7:0] r1);
    int hold [8];
    for (int i = 0; i < 8; i++) hold[i] = 0;
    r0 = 'x; r1 = 'x;
    bus.start = 1'b1; bus.a_in = a; bus.b_in = b;
    @(negedge clk);
    bus.start = 1'b0; m = 0;
    while (!bus.done && m < 40) begin
      if (bus.busy) hold[bus.alu_opcode]++;
      if (m == rd_m + 1) r0 = bus.rd_data;
      if (m == rd_m + 2) r1 = bus.rd_data;
      bus.start = (m == rs_m);
      if (m == rs_m) begin bus.a_in = 4'hF; bus.b_in = 4'hF; end
      bus.rd_en = (m == rd_m) || (m == rd_m + 1);
      bus.rd_addr = 3'd2;
      @(negedge clk);
      m++;
    end
    bus.start = 1'b0; bus.rd_en = 1'b0;
    for (int i = 0; i < N; i++) chk("opcode_hold", 8'(hold[i]), 8'(S + 1));
  endtask
  task automatic rd(input logic [2:0] addr, input logic [7:0] exp);
    bus.rd_en = 1'b1; bus.rd_addr = addr;
    @(negedge clk);
    bus.rd_en = 1'b0;
    chk("read_data", bus.rd_data, exp);
    chk("read_valid", bus.rd_valid, 1'b1);
    chk("read_err", bus.rd_err, int'(addr) >= N);
  endtask
  int m;
  logic [7:0] r0, r1;
  logic [7:0] e1 [6] = '{8'h04, 8'hFE, 8'h03, 8'h01, 8'h03, 8'h02};
  logic [7:0] e2 [6] = '{8'h0B, 8'h05, 8'h18, 8'h00, 8'h0B, 8'h0B};
  logic [7:0] e3 [6] = '{8'h07, 8'hFD, 8'h0A, 8'h00, 8'h07, 8'h07};
  initial begin
    bus.start = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.rd_en = 1'b0; bus.rd_addr = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_opcode", bus.alu_opcode, 3'd0);
    rst_n = 1'b1;
    @(negedge clk);
    sweep(4'd1, 4'd3, 100, 100, m, r0, r1);
    chk("done_latency_1", 8'(m), 8'd12);
    repeat (3) @(negedge clk);
    chk("done_level", bus.done, 1'b1);
    for (int i = 0; i < N; i++) rd(3'(i), e1[i]);
    sweep(4'd8, 4'd3, 100, 100, m, r0, r1);
    chk("done_latency_2", 8'(m), 8'd12);
    for (int i = 0; i < N; i++) rd(3'(i), e2[i]);
    sweep(4'd2, 4'd5, 3, 100, m, r0, r1);
    chk("done_latency_restart", 8'(m), 8'd12);
    for (int i = 0; i < N; i++) rd(3'(i), e3[i]);
    sweep(4'd3, 4'd3, 100, 5, m, r0, r1);
    chk("rbw_old", r0, 8'h0A);
    chk("rbw_new", r1, 8'h09);
    rd(3'd7, 8'h00);
    @(negedge clk);
    chk("oob_err_one_cycle", bus.rd_err, 1'b0);
    chk("oob_valid_one_cycle", bus.rd_valid, 1'b0);
    bus.start = 1'b1; bus.a_in = 4'd5; bus.b_in = 4'd6;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    chk("midreset_busy", bus.busy, 1'b0);
    chk("midreset_done", bus.done, 1'b0);
    rst_n = 1'b1; bus.start = 1'b0;
    @(negedge clk);
    chk("reset_start_ignored", bus.busy, 1'b0);
    for (int i = 0; i < N; i++) rd(3'(i), 8'h00);
    repeat (800) begin
      bus.start = ($urandom_range(0, 9) == 0);
      bus.a_in = 4'($urandom);
      bus.b_in = 4'($urandom);
      bus.rd_en = 1'($urandom);
      bus.rd_addr = 3'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1; bus.start = 1'b0; bus.rd_en = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
